bcd2b: RTL
==========

BCD2B -- requirements
Module: bcd2b

Interface
REQ-001 The module SHALL have no parameters; widths are fixed (3 BCD digits in, 8-bit binary out).
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a conversion; sampled only in IDLE.
REQ-005 bcd  input  12  packed BCD: [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-006 binary  output  8  converted result; holds until the next done.
REQ-007 busy  output  1  high from the accepting edge until done deasserts.
REQ-008 done  output  1  one-cycle pulse when binary/err are updated.
REQ-009 err  output  1  error flag of the last conversion; valid with done, held afterwards.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT, ADJ, DONE.
- Algorithm: reverse double-dabble on a 20-bit working register {bcd_reg[11:0], bin_reg[7:0]}.
REQ-011 IDLE with start=1 (the accepting edge, edge 0) SHALL do the following.
- Load bcd_reg=bcd and bin_reg=0.
- Clear the digit index and the shift counter.
- Set busy=1.
- Go to SHIFT.
REQ-012 At the accepting edge, if any nibble of bcd exceeds 9, the FSM SHALL go directly to DONE with an invalid flag set; done then rises at edge 1.
REQ-013 SHIFT SHALL logically right-shift the 20-bit register by 1 and increment the shift counter.
- Shifts 1-7: go to ADJ with digit index 0.
- Shift 8: go to DONE.
REQ-014 ADJ SHALL examine one digit per cycle, index 0, then 1, then 2.
- If the digit is >= 8, subtract 3 from it.
- After index 2, go to SHIFT.
REQ-015 Latency SHALL be fixed for valid input: done rises at edge 30 after the accepting edge.
- 7 x (1 shift + 3 ADJ) + 1 final shift + 1 DONE.
REQ-016 DONE SHALL assert done for exactly one cycle, clear busy, and return to IDLE.
- Valid, bcd_reg==0: binary=bin_reg, err=0.
- Valid, bcd_reg!=0 (value > 255): binary=8'hFF (saturate), err=1.
- Invalid digit: binary=8'h00, err=1.
REQ-017 start while busy SHALL be ignored, with no queuing.
- start in the same cycle as the done pulse is also ignored.
- start is accepted again from the first IDLE cycle.
REQ-018 bcd SHALL be sampled only at the accepting edge; later changes do not affect the conversion in progress.
REQ-019 All arithmetic SHALL be 4-bit per digit; subtract-3 is applied only to digits >= 8, so no digit underflow is possible.

Reset
REQ-020 rst=1 SHALL force the following at the next edge, from any state.
- State IDLE.
- binary=8'h00, busy=0, done=0, err=0.
- Working register, digit index and shift counter cleared.
REQ-021 rst SHALL take priority over start in the same cycle.
- A conversion aborted mid-operation produces no done pulse.

Configuration
REQ-022 With macro BCD2B_AUTO_START_EN defined, the internal start SHALL be (bcd != last_accepted_bcd) OR start.
- last_accepted_bcd resets to 12'h000 and is updated at each accepting edge.
- This matches the change-triggered behaviour of the binary-to-BCD sibling block.
REQ-023 Without BCD2B_AUTO_START_EN, only the start port SHALL initiate conversion, and no last_accepted_bcd register exists.

Structure
REQ-024 Shared package bcd_pkg SHALL hold the following.
- State enum typedef.
- Constants NUM_DIGITS=3, BIN_W=8, BCD_W=12, ADJ_THRESH=4'd8, ADJ_VAL=4'd3, LAST_SHIFT=8.
REQ-025 One sub-module, bcd_digit_valid, SHALL be used: combinational 4-bit in, 1-bit out (nibble <= 9), instantiated per digit for REQ-012.

Verification
REQ-026 bcd=12'h255, start pulse -> done at edge 30, binary=8'hFF, err=0, busy high for edges 0-30.
REQ-027 bcd=12'h128 -> binary=8'h80, err=0; bcd=12'h000 -> binary=8'h00, err=0, both at edge 30.
REQ-028 bcd=12'h256 -> done at edge 30, binary=8'hFF, err=1; bcd=12'h999 -> binary=8'hFF, err=1.
REQ-029 bcd=12'h1A3 -> done at edge 1, binary=8'h00, err=1; a subsequent 12'h042 -> binary=8'h2A, err=0.
REQ-030 Start 12'h100, then the following; repeat with BCD2B_AUTO_START_EN defined and bcd stepping 12'h000 -> 12'h037 with start=0 -> binary=8'h25.
- Pulse start again at edge 5: ignored.
- Assert rst at edge 10: no done, outputs zero next cycle.
- Start 12'h064: binary=8'h40 at edge 30.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ADJ,
        DONE
    } state_t;

    localparam int          NUM_DIGITS = 3;
    localparam int          BIN_W      = 8;
    localparam int          BCD_W      = 12;
    localparam logic [3:0]  ADJ_THRESH = 4'd8;
    localparam logic [3:0]  ADJ_VAL    = 4'd3;
    localparam int          LAST_SHIFT = 8;

endpackage

// File: rtl/bcd_digit_valid.sv
// Combinational check that one BCD nibble holds a legal decimal digit (0-9).
module bcd_digit_valid (
    input  logic [3:0] digit,
    output logic       valid
);

    assign valid = (digit <= 4'd9);

endmodule

// File: rtl/bcd2b.sv
// Three-digit BCD to 8-bit binary converter (reverse double-dabble, fixed latency).
// Optional BCD2B_AUTO_START_EN: also start a conversion whenever bcd differs from the last accepted value.
module bcd2b
    import bcd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] bcd,
    output logic [7:0]  binary,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t                  state;
    logic [BCD_W-1:0]        bcd_reg;
    logic [BIN_W-1:0]        bin_reg;
    logic [1:0]              dig_idx;
    logic [3:0]              shift_cnt;
    logic                    invalid;
    logic [NUM_DIGITS-1:0]   digit_ok;
    logic                    all_valid;
    logic                    start_int;
    logic                    accept;
    logic [3:0]              cur_digit;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_valid
        bcd_digit_valid u_valid (
            .digit (bcd[4*g +: 4]),
            .valid (digit_ok[g])
        );
    end

    assign all_valid = &digit_ok;
    assign cur_digit = bcd_reg[{dig_idx, 2'b00} +: 4];

`ifdef BCD2B_AUTO_START_EN
    logic [BCD_W-1:0] last_accepted_bcd;

    assign start_int = start | (bcd != last_accepted_bcd);

    always_ff @(posedge clk) begin
        if (rst)
            last_accepted_bcd <= '0;
        else if (accept)
            last_accepted_bcd <= bcd;
    end
`else
    assign start_int = start;
`endif

    // The done-pulse cycle is spent in IDLE, so starts are blocked there until done drops.
    assign accept = (state == IDLE) && !done && start_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bcd_reg   <= '0;
            bin_reg   <= '0;
            dig_idx   <= '0;
            shift_cnt <= '0;
            invalid   <= 1'b0;
            binary    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (done) begin
                        busy <= 1'b0;
                    end else if (accept) begin
                        bcd_reg   <= bcd;
                        bin_reg   <= '0;
                        dig_idx   <= '0;
                        shift_cnt <= '0;
                        invalid   <= !all_valid;
                        busy      <= 1'b1;
                        state     <= all_valid ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    {bcd_reg, bin_reg} <= {1'b0, bcd_reg, bin_reg[BIN_W-1:1]};
                    shift_cnt          <= shift_cnt + 4'd1;
                    dig_idx            <= '0;
                    if (shift_cnt == 4'(LAST_SHIFT - 1))
                        state <= DONE;
                    else
                        state <= ADJ;
                end
                ADJ: begin
                    if (cur_digit >= ADJ_THRESH)
                        bcd_reg[{dig_idx, 2'b00} +: 4] <= cur_digit - ADJ_VAL;
                    if (dig_idx == 2'(NUM_DIGITS - 1))
                        state <= SHIFT;
                    else
                        dig_idx <= dig_idx + 2'd1;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    if (invalid) begin
                        binary <= '0;
                        err    <= 1'b1;
                    end else if (bcd_reg != '0) begin
                        binary <= '1;
                        err    <= 1'b1;
                    end else begin
                        binary <= bin_reg;
                        err    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
